// File: rtl/neuron_train_ctrl_pkg.sv
// Shared types for the perceptron training controller: FSM state encoding,
// strobe bundle and default sizing.
package neuron_train_ctrl_pkg;

  localparam int DEFAULT_MAX_EPOCHS = 64;
  localparam int DEFAULT_EPOCH_W    = 8;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_N    = 4'd1,
    S_INIT      = 4'd2,
    S_REQ       = 4'd3,
    S_EVAL      = 4'd4,
    S_UPDATE    = 4'd5,
    S_NEXT      = 4'd6,
    S_CHECK     = 4'd7,
    S_EPOCH_END = 4'd8,
    S_DONE      = 4'd9
  } state_e;

  // One bit per datapath command; ld_x and ld_w each fan out to three load enables.
  typedef struct packed {
    logic sample_req;
    logic dp_reset;
    logic flag_reset;
    logic counter_reset;
    logic counter_en;
    logic ld_n;
    logic ld_x;
    logic ld_flag;
    logic ld_w;
  } strobe_t;

  function automatic logic is_busy(input state_e s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/neuron_train_ctrl_if.sv
// Sample-source handshake and datapath command/status bundle between the
// training controller (master) and the neuron datapath / sample memory (slave).
interface neuron_train_ctrl_if;

  logic sampleReq;
  logic sampleAck;
  logic yEqualt;
  logic flagEOF;
  logic reset;
  logic flagReset;
  logic counterReset;
  logic counterEn;
  logic ldRegN;
  logic ldRegx1;
  logic ldRegx2;
  logic ldRegT;
  logic ldRegW1;
  logic ldRegW2;
  logic ldRegB;
  logic ldRegFlag;

  modport master (
    input  sampleAck, yEqualt, flagEOF,
    output sampleReq, reset, flagReset, counterReset, counterEn, ldRegN,
           ldRegx1, ldRegx2, ldRegT, ldRegW1, ldRegW2, ldRegB, ldRegFlag
  );

  modport slave (
    output sampleAck, yEqualt, flagEOF,
    input  sampleReq, reset, flagReset, counterReset, counterEn, ldRegN,
           ldRegx1, ldRegx2, ldRegT, ldRegW1, ldRegW2, ldRegB, ldRegFlag
  );

endinterface

// File: rtl/neuron_train_ctrl_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module neuron_train_ctrl_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/neuron_train_ctrl.sv
// Perceptron training sequencer: loads N, fetches samples over req/ack, evaluates,
// updates weights on misclassification and repeats epochs until clean or MAX_EPOCHS.
module neuron_train_ctrl
  import neuron_train_ctrl_pkg::*;
#(
  parameter int MAX_EPOCHS = DEFAULT_MAX_EPOCHS,
  parameter int EPOCH_W    = DEFAULT_EPOCH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  neuron_train_ctrl_if.master dp,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epochCount
);

  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCHS - 1);

  state_e               r_state;
  state_e               w_next;
  strobe_t              w_strb;
  logic                 r_epoch_err;
  logic                 w_err_set;
  logic                 w_err_clr;
  logic                 r_done;
  logic                 r_converged;
  logic                 w_set_done;
  logic                 w_conv_val;
  logic                 w_start_ok;
  logic                 w_epoch_inc;
  logic [EPOCH_W-1:0]   w_epoch_count;

  assign w_start_ok = (r_state == S_IDLE) && start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next      = r_state;
    w_strb      = '0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_set_done  = 1'b0;
    w_conv_val  = 1'b0;
    w_epoch_inc = 1'b0;

    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD_N;
      S_LOAD_N: begin
        w_strb.ld_n = 1'b1;
        w_next      = S_INIT;
      end
      S_INIT: begin
        // The datapath keeps its N register through this clear.
        w_strb.dp_reset      = 1'b1;
        w_strb.flag_reset    = 1'b1;
        w_strb.counter_reset = 1'b1;
        w_err_clr            = 1'b1;
        w_next               = S_CHECK;
      end
      S_REQ: begin
        w_strb.sample_req = 1'b1;
        if (dp.sampleAck) begin
          w_strb.ld_x = 1'b1;
          w_next      = S_EVAL;
        end
      end
      S_EVAL: begin
        w_strb.ld_flag = 1'b1;
        if (dp.yEqualt) begin
          w_next = S_NEXT;
        end else begin
          w_err_set = 1'b1;
          w_next    = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_strb.ld_w = 1'b1;
        w_next      = S_NEXT;
      end
      S_NEXT: begin
        w_strb.counter_en = 1'b1;
        w_next            = S_CHECK;
      end
      S_CHECK:  w_next = dp.flagEOF ? S_EPOCH_END : S_REQ;
      S_EPOCH_END: begin
        w_epoch_inc = 1'b1;
        if (!r_epoch_err) begin
          w_set_done = 1'b1;
          w_conv_val = 1'b1;
          w_next     = S_DONE;
        end else if (w_epoch_count == LAST_EPOCH) begin
          w_set_done = 1'b1;
          w_next     = S_DONE;
        end else begin
          w_strb.flag_reset    = 1'b1;
          w_strb.counter_reset = 1'b1;
          w_err_clr            = 1'b1;
          w_next               = S_REQ;
        end
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    // Abort overrides everything: no datapath command and no bookkeeping this cycle.
    if (abort) begin
      w_next      = S_IDLE;
      w_strb      = '0;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      w_set_done  = 1'b0;
      w_epoch_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epoch_err <= 1'b0;
    end else if (w_err_clr) begin
      r_epoch_err <= 1'b0;
    end else if (w_err_set) begin
      r_epoch_err <= 1'b1;
    end
  end

  // done/converged stay latched after DONE until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_converged <= 1'b0;
    end else if (w_start_ok) begin
      r_done      <= 1'b0;
      r_converged <= 1'b0;
    end else if (w_set_done) begin
      r_done      <= 1'b1;
      r_converged <= w_conv_val;
    end
  end

  neuron_train_ctrl_counter #(
    .W (EPOCH_W)
  ) u_epoch_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_ok),
    .i_en    (w_epoch_inc),
    .o_count (w_epoch_count)
  );

  assign dp.sampleReq    = w_strb.sample_req;
  assign dp.reset        = w_strb.dp_reset;
  assign dp.flagReset    = w_strb.flag_reset;
  assign dp.counterReset = w_strb.counter_reset;
  assign dp.counterEn    = w_strb.counter_en;
  assign dp.ldRegN       = w_strb.ld_n;
  assign dp.ldRegx1      = w_strb.ld_x;
  assign dp.ldRegx2      = w_strb.ld_x;
  assign dp.ldRegT       = w_strb.ld_x;
  assign dp.ldRegW1      = w_strb.ld_w;
  assign dp.ldRegW2      = w_strb.ld_w;
  assign dp.ldRegB       = w_strb.ld_w;
  assign dp.ldRegFlag    = w_strb.ld_flag;

  assign busy       = is_busy(r_state);
  assign done       = r_done;
  assign converged  = r_converged;
  assign epochCount = w_epoch_count;

endmodule
